shift_window_ctrl: RTL and testbench

SHIFT_WINDOW_CTRL -- requirements
Module: shift_window_ctrl

---
 rtl/shift_window_ctrl_pkg.sv | 12 +
 rtl/shift_window_ctrl_if.sv | 26 ++
 rtl/shift_window_ctrl_char_classifier.sv | 11 +
 rtl/shift_window_ctrl.sv | 103 ++++++++++
 tb/tb_shift_window_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/shift_window_ctrl_pkg.sv
// sniff_pkg: window geometry, ASCII constants and controller state type
package sniff_pkg;
  localparam int WINDOW_DEPTH = 12;
  localparam int MAX_TOKEN = 10;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TAB = 8'h09;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_NINE = 8'h39;
  typedef enum logic [1:0] {IDLE, CHECK, REPORT, FLUSH} state_e;
endpackage

// File: rtl/shift_window_ctrl_if.sv
// shift_window_ctrl_if: byte input, flush, shift-register side and match/status bundle; slave = controller, master = driver
interface shift_window_ctrl_if;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic flush;
  logic sr_en;
  logic [7:0] sr_data_in;
  logic sr_is_number;
  logic sr_is_white;
  logic [sniff_pkg::WINDOW_DEPTH-1:0] sr_is_number_out;
  logic [sniff_pkg::WINDOW_DEPTH-1:0] sr_is_white_out;
  logic match_valid;
  logic [3:0] match_len;
  logic match_ready;
  logic overflow;
  logic [15:0] match_count;
  modport master (
    output in_valid, in_data, flush, sr_is_number_out, sr_is_white_out, match_ready,
    input in_ready, sr_en, sr_data_in, sr_is_number, sr_is_white, match_valid, match_len, overflow, match_count
  );
  modport slave (
    input in_valid, in_data, flush, sr_is_number_out, sr_is_white_out, match_ready,
    output in_ready, sr_en, sr_data_in, sr_is_number, sr_is_white, match_valid, match_len, overflow, match_count
  );
endinterface

// File: rtl/shift_window_ctrl_char_classifier.sv
// char_classifier: combinational digit/whitespace flags for one ASCII byte (data in; is_number, is_white out)
module char_classifier
  import sniff_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_number,
  output logic       is_white
);
  assign is_number = data >= ASC_ZERO && data <= ASC_NINE;
  assign is_white = data == ASC_SPACE || data == ASC_TAB || data == ASC_LF || data == ASC_CR;
endmodule

// File: rtl/shift_window_ctrl.sv
// shift_window_ctrl: feeds an external 12-deep shift register and reports whitespace-delimited digit tokens (clk, rst_n, bus slave)
module shift_window_ctrl
  import sniff_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  shift_window_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [3:0] fill_q, fill_d, flush_cnt_q, flush_cnt_d, match_len_q, match_len_d;
  logic overflow_q, overflow_d;
  logic [15:0] match_count_q, match_count_d;
  logic cls_number, cls_white, run_on, end_white, is_match, is_over;
  logic [WINDOW_DEPTH-1:0] dig, wht;
  logic [3:0] run;
  char_classifier u_cls (.data(bus.in_data), .is_number(cls_number), .is_white(cls_white));
  assign bus.in_ready = state_q == IDLE && rst_n;
  assign bus.match_valid = state_q == REPORT;
  assign bus.match_len = match_len_q;
  assign bus.overflow = overflow_q;
  assign bus.match_count = match_count_q;
  // slots not yet written since reset/flush hold stale data and count as whitespace
  always_comb begin
    for (int i = 0; i < WINDOW_DEPTH; i++) begin
      dig[i] = 4'(i) < fill_q && bus.sr_is_number_out[i];
      wht[i] = 4'(i) >= fill_q || bus.sr_is_white_out[i];
    end
  end
  always_comb begin
    run = '0;
    run_on = 1'b1;
    for (int i = 1; i < WINDOW_DEPTH; i++) begin
      run_on = run_on & dig[i];
      run = run + {3'b0, run_on};
    end
    end_white = run < 4'(WINDOW_DEPTH - 1) ? wht[run + 4'd1] : 1'b0;
    is_match = wht[0] && run != '0 && run <= 4'(MAX_TOKEN) && end_white;
    is_over = wht[0] && run == 4'(WINDOW_DEPTH - 1);
  end
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    flush_cnt_d = flush_cnt_q;
    match_len_d = match_len_q;
    overflow_d = overflow_q;
    match_count_d = match_count_q;
    bus.sr_en = 1'b0;
    bus.sr_data_in = bus.in_data;
    bus.sr_is_number = cls_number;
    bus.sr_is_white = cls_white;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
          flush_cnt_d = '0;
        end else if (bus.in_valid && bus.in_ready) begin
          bus.sr_en = 1'b1;
          fill_d = fill_q == 4'(WINDOW_DEPTH) ? fill_q : fill_q + 4'd1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = is_match ? REPORT : IDLE;
        match_len_d = is_match ? run : match_len_q;
        overflow_d = overflow_q | is_over;
      end
      REPORT: begin
        state_d = bus.match_ready ? IDLE : REPORT;
        match_count_d = bus.match_ready && ~&match_count_q ? match_count_q + 16'd1 : match_count_q;
      end
      FLUSH: begin
        bus.sr_en = 1'b1;
        bus.sr_data_in = ASC_SPACE;
        bus.sr_is_number = 1'b0;
        bus.sr_is_white = 1'b1;
        flush_cnt_d = flush_cnt_q + 4'd1;
        if (flush_cnt_q == 4'(WINDOW_DEPTH - 1)) begin
          state_d = IDLE;
          fill_d = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q <= '0;
      flush_cnt_q <= '0;
      match_len_q <= '0;
      overflow_q <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      flush_cnt_q <= flush_cnt_d;
      match_len_q <= match_len_d;
      overflow_q <= overflow_d;
      match_count_q <= match_count_d;
    end
  end
endmodule

// File: tb/tb_shift_window_ctrl.sv
// tb_shift_window_ctrl: directed and random token streams checked against a byte-history reference model
module tb_shift_window_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  shift_window_ctrl_if bus();
  logic [11:0] sr_num = '0, sr_wht = '0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] hist[$];
  bit ovf_m = 1'b0;
  logic [15:0] cnt_m = '0;
  bit obs_match;
  logic [3:0] obs_len;
  shift_window_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.sr_en) begin
    sr_num <= {sr_num[10:0], bus.sr_is_number};
    sr_wht <= {sr_wht[10:0], bus.sr_is_white};
  end
  assign bus.sr_is_number_out = sr_num;
  assign bus.sr_is_white_out = sr_wht;
  function automatic bit is_dig(input logic [7:0] b);
    return b >= "0" && b <= "9";
  endfunction
  function automatic bit is_ws(input logic [7:0] b);
    return b == " " || b == 8'h09 || b == 8'h0A || b == 8'h0D;
  endfunction
  task automatic send(input logic [7:0] b, input int hold, input bit flush_in_report);
    int n, k;
    bit em;
    logic [3:0] el;
    bus.in_valid = 1'b1; bus.in_data = b; #1;
    n_chk += 5;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_in_ready got %b want 1", bus.in_ready); end
    if (bus.sr_en !== 1'b1) begin n_fail++; $display("FAIL accept_sr_en got %b want 1", bus.sr_en); end
    if (bus.sr_data_in !== b) begin n_fail++; $display("FAIL accept_sr_data got %h want %h", bus.sr_data_in, b); end
    if (bus.sr_is_number !== is_dig(b)) begin n_fail++; $display("FAIL class_number byte %h got %b want %b", b, bus.sr_is_number, is_dig(b)); end
    if (bus.sr_is_white !== is_ws(b)) begin n_fail++; $display("FAIL class_white byte %h got %b want %b", b, bus.sr_is_white, is_ws(b)); end
    @(posedge clk); @(negedge clk);
    n_chk += 2;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL check_in_ready got %b want 0", bus.in_ready); end
    if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL check_sr_en got %b want 0", bus.sr_en); end
    bus.in_valid = 1'b0;
    hist.push_back(b);
    n = hist.size(); em = 1'b0; el = '0; k = 0;
    if (is_ws(b)) begin
      while (k < 11 && n - 2 - k >= 0 && is_dig(hist[n-2-k])) k++;
      if (k == 11) ovf_m = 1'b1;
      else if (k > 0 && (n - 2 - k < 0 || is_ws(hist[n-2-k]))) begin em = 1'b1; el = 4'(k); end
    end
    @(negedge clk);
    obs_match = bus.match_valid; obs_len = bus.match_len;
    n_chk += 2;
    if (bus.match_valid !== em) begin n_fail++; $display("FAIL match_valid byte %h got %b want %b", b, bus.match_valid, em); end
    if (bus.overflow !== ovf_m) begin n_fail++; $display("FAIL overflow got %b want %b", bus.overflow, ovf_m); end
    if (em) begin
      n_chk++;
      if (bus.match_len !== el) begin n_fail++; $display("FAIL match_len got %0d want %0d", bus.match_len, el); end
      for (int i = 0; i < hold; i++) begin
        if (flush_in_report) bus.flush = 1'b1;
        #1;
        n_chk += 4;
        if (bus.match_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", bus.match_valid); end
        if (bus.match_len !== el) begin n_fail++; $display("FAIL hold_len got %0d want %0d", bus.match_len, el); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready got %b want 0", bus.in_ready); end
        if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL hold_sr_en got %b want 0", bus.sr_en); end
        @(negedge clk);
      end
      bus.flush = 1'b0;
    end
    if (bus.match_valid) begin
      bus.match_ready = 1'b1;
      @(posedge clk);
      if (em) cnt_m = cnt_m == 16'hFFFF ? cnt_m : cnt_m + 16'd1;
      @(negedge clk);
      bus.match_ready = 1'b0;
      n_chk += 3;
      if (bus.match_valid !== 1'b0) begin n_fail++; $display("FAIL done_valid got %b want 0", bus.match_valid); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL done_in_ready got %b want 1", bus.in_ready); end
      if (bus.match_count !== cnt_m) begin n_fail++; $display("FAIL match_count got %0d want %0d", bus.match_count, cnt_m); end
    end
  endtask
  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send(s[i], hold, 1'b0);
  endtask
  task automatic run_flush(input int reset_at);
    bus.flush = 1'b1; #1;
    n_chk++;
    if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL flush_req_sr_en got %b want 0", bus.sr_en); end
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      n_chk += 5;
      if (bus.sr_en !== 1'b1) begin n_fail++; $display("FAIL flush_sr_en cycle %0d got %b want 1", i, bus.sr_en); end
      if (bus.sr_data_in !== 8'h20) begin n_fail++; $display("FAIL flush_data cycle %0d got %h want 20", i, bus.sr_data_in); end
      if (bus.sr_is_white !== 1'b1) begin n_fail++; $display("FAIL flush_white cycle %0d got %b want 1", i, bus.sr_is_white); end
      if (bus.sr_is_number !== 1'b0) begin n_fail++; $display("FAIL flush_number cycle %0d got %b want 0", i, bus.sr_is_number); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
      if (i == reset_at) begin
        rst_n = 1'b0; #1;
        hist.delete(); ovf_m = 1'b0; cnt_m = '0;
        n_chk += 5;
        if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL rst_sr_en got %b want 0", bus.sr_en); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        if (bus.match_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", bus.match_count); end
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
        if (bus.match_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.match_valid); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    hist.delete(); ovf_m = 1'b0;
    n_chk += 4;
    if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL flush_end_sr_en got %b want 0", bus.sr_en); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_end_in_ready got %b want 1", bus.in_ready); end
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL flush_end_overflow got %b want 0", bus.overflow); end
    if (bus.match_count !== cnt_m) begin n_fail++; $display("FAIL flush_end_count got %0d want %0d", bus.match_count, cnt_m); end
  endtask
  task automatic test_reset;
    bus.in_valid = 1'b1; bus.in_data = "5"; bus.flush = 1'b0; bus.match_ready = 1'b0;
    @(negedge clk);
    n_chk += 6;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    if (bus.sr_en !== 1'b0) begin n_fail++; $display("FAIL reset_sr_en got %b want 0", bus.sr_en); end
    if (bus.match_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.match_valid); end
    if (bus.match_len !== 4'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", bus.match_len); end
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    if (bus.match_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.match_count); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1; #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask
  task automatic test_basic;
    send_str("42 ", 0);
    n_chk += 3;
    if (obs_match !== 1'b1) begin n_fail++; $display("FAIL basic_match got %b want 1", obs_match); end
    if (obs_len !== 4'd2) begin n_fail++; $display("FAIL basic_len got %0d want 2", obs_len); end
    if (bus.match_count !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", bus.match_count); end
  endtask
  task automatic test_limits;
    send_str(" 1234567890 ", 1);
    n_chk++;
    if (obs_len !== 4'd10) begin n_fail++; $display("FAIL max_len got %0d want 10", obs_len); end
    send_str(" 12345678901 ", 0);
    n_chk += 2;
    if (obs_match !== 1'b0) begin n_fail++; $display("FAIL over_match got %b want 0", obs_match); end
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL over_flag got %b want 1", bus.overflow); end
    send_str("a12 ", 0);
    n_chk++;
    if (obs_match !== 1'b0) begin n_fail++; $display("FAIL nonwhite_match got %b want 0", obs_match); end
  endtask
  task automatic test_hold;
    send("5", 0, 1'b0);
    send(" ", 5, 1'b1);
    n_chk++;
    if (obs_len !== 4'd1) begin n_fail++; $display("FAIL hold_first_len got %0d want 1", obs_len); end
  endtask
  task automatic test_flush;
    run_flush(0);
    send_str("7 ", 0);
    n_chk += 2;
    if (obs_match !== 1'b1) begin n_fail++; $display("FAIL post_flush_match got %b want 1", obs_match); end
    if (obs_len !== 4'd1) begin n_fail++; $display("FAIL post_flush_len got %0d want 1", obs_len); end
  endtask
  task automatic test_random(input int count);
    logic [7:0] b;
    int r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      if (r == 5) b = " ";
      else if (r == 6) b = ($urandom_range(0, 2) == 0) ? 8'h09 : ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
      else if (r == 7) b = 8'(8'h61 + $urandom_range(0, 25));
      else b = 8'(8'h30 + $urandom_range(0, 9));
      send(b, $urandom_range(0, 2), 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_hold();
    test_flush();
    test_random(300);
    run_flush(5);
    test_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
